pwm_breath_ctrl: RTL

- Sequencer for a single breathing LED.
- Owns the PWM period timebase and runs the duty-cycle ramp FSM: rise, hold high, fall, hold low, repeat.
- Accepts run-time configuration commands (start, stop, ramp step, hold time) over a valid/ready handshake.
- All duty changes apply only at PWM period boundaries, so the output never glitches. Sits between board-level control logic and the LED pin.

---
 rtl/pwm_breath_pkg.sv | 25 ++
 rtl/pwm_timebase.sv | 48 ++++
 rtl/pwm_breath_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_breath_pkg.sv
// -----------------------------------------------------------------------------
// pwm_breath_pkg
//   Shared types and constants for the breathing-LED sequencer.
//   - breath_state_e : ramp FSM states
//   - OP_*           : cmd_op encodings
//   - PWM_CYCLE_DEF  : default clocks per PWM period (10 ms at 50 MHz)
// -----------------------------------------------------------------------------
package pwm_breath_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRise,
        StHoldHi,
        StFall,
        StHoldLo
    } breath_state_e;

    localparam logic [1:0] OP_STOP     = 2'd0;
    localparam logic [1:0] OP_START    = 2'd1;
    localparam logic [1:0] OP_SET_STEP = 2'd2;
    localparam logic [1:0] OP_SET_HOLD = 2'd3;

    localparam int unsigned PWM_CYCLE_DEF = 500_000;

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
//   Free-running PWM period counter. Counts 0..PWM_CYCLE-1 and wraps.
//   Ports:
//     clk         : system clock
//     rst_n       : asynchronous active-low reset
//     cnt         : current position inside the PWM period
//     period_tick : high on the last clock of every period
// -----------------------------------------------------------------------------
module pwm_timebase
    import pwm_breath_pkg::*;
#(
    parameter int unsigned PWM_CYCLE = PWM_CYCLE_DEF,
    parameter int unsigned CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             period_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_CYCLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last;

    assign last = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt         = cnt_q;
    assign period_tick = last;

endmodule

// File: rtl/pwm_breath_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_breath_ctrl
//   Breathing-LED sequencer: PWM timebase, duty ramp FSM
//   (rise / hold high / fall / hold low) and a one-entry command slot.
//   Every duty, state and configuration change happens on a period boundary.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     cmd_valid   : command present
//     cmd_ready   : command slot free
//     cmd_op      : 0=STOP 1=START 2=SET_STEP 3=SET_HOLD
//     cmd_data    : operand (step uses all bits, hold uses the low HOLD_W bits)
//     led         : LED drive, active-low
//     busy        : FSM not idle
//     duty        : duty currently applied, in clocks
//     period_tick : pulse on the last clock of each PWM period
// -----------------------------------------------------------------------------
module pwm_breath_ctrl
    import pwm_breath_pkg::*;
#(
    parameter int unsigned PWM_CYCLE = PWM_CYCLE_DEF,
    parameter int unsigned CNT_W     = 19,
    parameter int unsigned STEP_DEF  = 25_000,
    parameter int unsigned HOLD_DEF  = 10,
    parameter int unsigned HOLD_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_data,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] duty,
    output logic             period_tick
);

    localparam logic [CNT_W-1:0]  DUTY_MAX   = CNT_W'(PWM_CYCLE);
    localparam logic [CNT_W:0]    DUTY_MAX_W = (CNT_W + 1)'(PWM_CYCLE);
    localparam logic [CNT_W-1:0]  STEP_RST   = CNT_W'(STEP_DEF);
    localparam logic [HOLD_W-1:0] HOLD_RST   = HOLD_W'(HOLD_DEF);

    // -------------------------------------------------------------------------
    // Timebase
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             tick;

    pwm_timebase #(
        .PWM_CYCLE (PWM_CYCLE),
        .CNT_W     (CNT_W)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt         (cnt),
        .period_tick (tick)
    );

    // -------------------------------------------------------------------------
    // One-entry command slot. Ready only while empty, so a held cmd_valid
    // waits instead of overwriting. The slot drains on every boundary; a
    // command captured on the boundary clock itself waits a full period.
    // -------------------------------------------------------------------------
    logic             pend_valid_q;
    logic [1:0]       pend_op_q;
    logic [CNT_W-1:0] pend_data_q;
    logic             cmd_accept;

    assign cmd_ready  = ~pend_valid_q;
    assign cmd_accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_op_q    <= OP_STOP;
            pend_data_q  <= '0;
        end else if (cmd_accept) begin
            pend_valid_q <= 1'b1;
            pend_op_q    <= cmd_op;
            pend_data_q  <= cmd_data;
        end else if (tick) begin
            pend_valid_q <= 1'b0;
        end
    end

    // Hold operand zero-extended so any HOLD_W vs CNT_W ratio works.
    logic [CNT_W+HOLD_W-1:0] data_ext;
    logic                    unused_data_ext;

    assign data_ext        = {{HOLD_W{1'b0}}, pend_data_q};
    assign unused_data_ext = ^data_ext[CNT_W+HOLD_W-1:HOLD_W];

    // -------------------------------------------------------------------------
    // Ramp FSM: state register
    // -------------------------------------------------------------------------
    breath_state_e     state_q, state_d;
    logic [CNT_W-1:0]  duty_q, duty_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            duty_q     <= '0;
            step_q     <= STEP_RST;
            hold_q     <= HOLD_RST;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Ramp FSM: next state. On a boundary the pending command is applied
    // first. STOP/START are transitions in their own right; SET_STEP and
    // SET_HOLD only update configuration, and the state's ramp rule then runs
    // with the new value in the same boundary.
    // -------------------------------------------------------------------------
    logic             ramp_en;
    logic [CNT_W:0]   ramp_sum;

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        step_d     = step_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        ramp_en    = 1'b0;
        ramp_sum   = '0;

        if (tick) begin
            ramp_en = 1'b1;
            if (pend_valid_q) begin
                unique case (pend_op_q)
                    OP_STOP: begin
                        state_d = StIdle;
                        duty_d  = '0;
                        ramp_en = 1'b0;
                    end
                    OP_START: begin
                        // From idle the ramp starts at 0; otherwise it
                        // restarts rising from wherever the duty is now.
                        state_d = StRise;
                        if (state_q == StIdle) begin
                            duty_d = '0;
                        end
                        ramp_en = 1'b0;
                    end
                    OP_SET_STEP: begin
                        step_d = (pend_data_q == '0) ? CNT_W'(1) : pend_data_q;
                    end
                    OP_SET_HOLD: begin
                        hold_d = data_ext[HOLD_W-1:0];
                    end
                    default: ;
                endcase
            end

            // One extra bit so a large step saturates instead of wrapping.
            ramp_sum = {1'b0, duty_q} + {1'b0, step_d};

            if (ramp_en) begin
                unique case (state_q)
                    StIdle: begin
                        duty_d = '0;
                    end
                    StRise: begin
                        if (ramp_sum >= DUTY_MAX_W) begin
                            duty_d     = DUTY_MAX;
                            hold_cnt_d = '0;
                            state_d    = StHoldHi;
                        end else begin
                            duty_d = ramp_sum[CNT_W-1:0];
                        end
                    end
                    StHoldHi: begin
                        // Compare before incrementing: hold=0 is one period.
                        if (hold_cnt_q == hold_d) begin
                            state_d = StFall;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    StFall: begin
                        if (duty_q <= step_d) begin
                            duty_d     = '0;
                            hold_cnt_d = '0;
                            state_d    = StHoldLo;
                        end else begin
                            duty_d = duty_q - step_d;
                        end
                    end
                    StHoldLo: begin
                        if (hold_cnt_q == hold_d) begin
                            state_d = StRise;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        duty_d  = '0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Ramp FSM: outputs (registered)
    // -------------------------------------------------------------------------
    logic led_d, led_q;
    logic busy_d, busy_q;

    always_comb begin
        busy_d = (state_d != StIdle);
        led_d  = ~(cnt < duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            busy_q <= busy_d;
        end
    end

    assign led         = led_q;
    assign busy        = busy_q;
    assign duty        = duty_q;
    assign period_tick = tick;

endmodule
